seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameters SHALL be PAT_W (default 8, max pattern length in bits) and CNT_W (default 16, match-counter width).
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port cfg_valid, input, 1: configuration offer.
REQ-005 Port cfg_ready, output, 1: configuration accepted this cycle when high together with cfg_valid.
REQ-006 Port cfg_pattern, input, PAT_W: target pattern; the LSB is the last bit received.
REQ-007 Port cfg_len, input, 4: pattern length; legal range is 1..PAT_W.
REQ-008 Port cfg_overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-009 Port start, input, 1: one-cycle arm request.
REQ-010 Port stop, input, 1: one-cycle disarm request.
REQ-011 Port x, input, 1: serial data bit.
REQ-012 Port x_valid, input, 1: x is sampled only when this is high.
REQ-013 Port y, output, 1: registered one-cycle match pulse.
REQ-014 Port busy, output, 1: high while in RUN.
REQ-015 Port match_count, output, CNT_W: number of matches since the last start.
REQ-016 Port err, output, 1: sticky error flag.

Function
REQ-017 The FSM SHALL have states IDLE and RUN; a configured flag SHALL record that a legal configuration is held.
REQ-018 cfg_ready SHALL equal (state==IDLE); in RUN, cfg_valid SHALL be ignored without error.
REQ-019 An IDLE handshake with legal cfg_len SHALL latch pattern, len and overlap, and set configured the next cycle.
REQ-020 An IDLE handshake with cfg_len 0 or >PAT_W SHALL set err, leave the held configuration unchanged, and leave configured unchanged.
REQ-021 When start is seen in IDLE with configured=1 and stop=0, the FSM SHALL enter RUN next cycle, clear match_count, history and the fill counter, and hold y=0.
REQ-022 start in IDLE with configured=0 SHALL set err and remain in IDLE.
REQ-023 start together with stop in IDLE: stop SHALL win and the FSM SHALL stay in IDLE, without setting err.
REQ-024 start in RUN SHALL be ignored.
REQ-025 stop in RUN SHALL return the FSM to IDLE next cycle; a bit sampled in that same cycle SHALL be discarded.
REQ-026 In RUN, each x_valid cycle SHALL shift x into the history LSB and increment the fill counter, saturating at PAT_W.
REQ-027 Match condition: fill counter after the shift >= len AND the low len bits of history == the low len bits of pattern.
REQ-028 On a match, y SHALL be 1 in the cycle after the sampling edge, for exactly one cycle.
REQ-029 On a match, match_count SHALL increment, saturating at all-ones with no wrap.
REQ-030 On a match with overlap=0, the fill counter SHALL reset to 0 so that no bit is shared between matches.
REQ-031 On a match with overlap=1, the fill counter SHALL be kept.
REQ-032 x_valid=0 cycles SHALL not change history, the fill counter or y (y=0).
REQ-033 x and x_valid SHALL be ignored in IDLE.
REQ-034 match_count SHALL hold its value after stop until the next start.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 Asserting rst at any time, including mid-RUN, SHALL force on the same edge: state=IDLE, configured=0, pattern=0, len=0, overlap=0, history=0, fill counter=0, y=0, busy=0, match_count=0, err=0, cfg_ready=1 after release.

Structure
REQ-037 Package seq_det_pkg SHALL hold the state enum {IDLE, RUN}, the PAT_W and CNT_W defaults, and the len width constant.
REQ-038 Sub-module seq_match_core SHALL contain history, the fill counter and the compare (inputs: shift, clear, pattern, len, overlap; output: match).
REQ-039 seq_det_ctrl SHALL own the FSM, the configuration registers, the counter and the err flag.

Verification
REQ-040 Config pattern=0x0B, len=4, overlap=0; start; bits 1,0,1,1,0,1,1 on consecutive x_valid -> single y pulse after bit 4; match_count=1.
REQ-041 Same stream with overlap=1 -> y after bit 4 and after bit 7; match_count=2.
REQ-042 cfg_len=0 then cfg_len=9 -> err=1, configured stays 0; start -> remains IDLE, busy=0.
REQ-043 Legal config, start, bits 1,0,1 then rst asserted mid-cycle -> all outputs zero immediately; after release, start without reconfiguration -> err=1.
REQ-044 Running, gaps of x_valid=0 inside 1,0,1,1 -> one y pulse; stop with a matching bit sampled the same cycle -> no y, busy=0 next cycle.
REQ-045 With CNT_W=2, pattern=1 and len=1, feed five 1s -> match_count saturates at 3; start and stop pulsed together in IDLE -> stays IDLE, err=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial sequence detector.
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int LEN_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Shift history, fill counter and masked pattern compare for the sequence detector.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_nxt;
  logic [PAT_W-1:0]  mask;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_shift;

  // match reflects the state the history would have after shifting x in
  always_comb begin
    history_nxt = (history << 1) | PAT_W'(x);
    fill_shift  = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
    mask        = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match = (int'(fill_shift) >= int'(len)) &&
            ((history_nxt & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= history_nxt;
      fill    <= (match && !overlap) ? '0 : fill_shift;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence detector controller: config handshake, IDLE/RUN FSM, match counter, sticky error.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             y,
  output logic             busy,
  output logic [CNT_W-1:0] match_count,
  output logic             err
);

  state_t           state;
  state_t           state_nxt;
  logic             configured;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             cfg_take;
  logic             cfg_legal;
  logic             start_go;
  logic             start_bad;
  logic             shift;
  logic             match;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);

  // stop outranks start in IDLE, and a bit arriving with stop in RUN is dropped
  always_comb begin
    state_nxt = state;
    cfg_take  = 1'b0;
    start_go  = 1'b0;
    start_bad = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        cfg_take = cfg_valid;
        if (start && !stop) begin
          if (configured) begin
            start_go  = 1'b1;
            state_nxt = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          shift = x_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      configured  <= 1'b0;
      pattern     <= '0;
      len         <= '0;
      overlap     <= 1'b0;
      err         <= 1'b0;
      match_count <= '0;
      y           <= 1'b0;
    end else begin
      if (cfg_take && cfg_legal) begin
        configured <= 1'b1;
        pattern    <= cfg_pattern;
        len        <= cfg_len;
        overlap    <= cfg_overlap;
      end
      if ((cfg_take && !cfg_legal) || start_bad) begin
        err <= 1'b1;
      end
      if (start_go) begin
        match_count <= '0;
      end else if (shift && match && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
      y <= shift && match;
    end
  end

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .clear  (start_go),
    .x      (x),
    .pattern(pattern),
    .len    (len),
    .overlap(overlap),
    .match  (match)
  );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl, including a CNT_W=2 instance for saturation.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       y;
  logic       busy;
  logic [15:0] match_count;
  logic       err;
  logic       cfg_ready2;
  logic       y2;
  logic       busy2;
  logic [1:0] match_count2;
  logic       err2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .start(start), .stop(stop), .x(x), .x_valid(x_valid), .y(y), .busy(busy),
    .match_count(match_count), .err(err)
  );

  seq_det_ctrl #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .start(start), .stop(stop), .x(x), .x_valid(x_valid), .y(y2), .busy(busy2),
    .match_count(match_count2), .err(err2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vx, input logic vvalid, input logic vstop);
    x = vx;
    x_valid = vvalid;
    stop = vstop;
    tick();
    x = 1'b0;
    x_valid = 1'b0;
    stop = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_valid = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = ov;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulseStart(input logic withStop);
    start = 1'b1;
    stop = withStop;
    tick();
    start = 1'b0;
    stop = 1'b0;
  endtask

  logic [6:0] stream;
  logic [6:0] yNoOv;
  logic [6:0] yOv;

  initial begin
    // bits in arrival order, index 0 first
    stream = 7'b1101101;
    yNoOv  = 7'b0001000;
    yOv    = 7'b1001000;

    doReset();
    checkOutput("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_y", {31'd0, y}, 32'd0);
    checkOutput("reset_count", {16'd0, match_count}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);

    // non-overlapping 1011 over 1,0,1,1,0,1,1
    configure(8'h0B, 4'd4, 1'b0);
    pulseStart(1'b0);
    checkOutput("noov_busy", {31'd0, busy}, 32'd1);
    checkOutput("noov_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(stream[i], 1'b1, 1'b0);
      checkOutput($sformatf("noov_y_bit%0d", i + 1), {31'd0, y}, {31'd0, yNoOv[i]});
    end
    checkOutput("noov_count", {16'd0, match_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("noov_stop_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("noov_count_held", {16'd0, match_count}, 32'd1);

    // overlapping, same stream, with ignored start/config while running
    configure(8'h0B, 4'd4, 1'b1);
    pulseStart(1'b0);
    checkOutput("ov_count_cleared", {16'd0, match_count}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(stream[i], 1'b1, 1'b0);
      checkOutput($sformatf("ov_y_bit%0d", i + 1), {31'd0, y}, {31'd0, yOv[i]});
    end
    checkOutput("ov_count", {16'd0, match_count}, 32'd2);
    pulseStart(1'b0);
    configure(8'h00, 4'd0, 1'b0);
    checkOutput("run_start_ignored", {16'd0, match_count}, 32'd2);
    checkOutput("run_cfg_no_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // illegal lengths, then start without a configuration
    doReset();
    configure(8'h0B, 4'd0, 1'b0);
    checkOutput("len0_err", {31'd0, err}, 32'd1);
    configure(8'h0B, 4'd9, 1'b0);
    pulseStart(1'b0);
    checkOutput("unconf_start_busy", {31'd0, busy}, 32'd0);
    checkOutput("unconf_start_err", {31'd0, err}, 32'd1);

    // reset in the middle of a run
    doReset();
    configure(8'h0B, 4'd4, 1'b0);
    pulseStart(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_y", {31'd0, y}, 32'd0);
    checkOutput("midrst_count", {16'd0, match_count}, 32'd0);
    checkOutput("midrst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    pulseStart(1'b0);
    checkOutput("midrst_start_err", {31'd0, err}, 32'd1);
    checkOutput("midrst_start_busy", {31'd0, busy}, 32'd0);

    // valid gaps inside 1,0,1,1, then a matching bit discarded by stop
    doReset();
    configure(8'h0B, 4'd4, 1'b0);
    pulseStart(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap_y0", {31'd0, y}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("gap_y1", {31'd0, y}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("gap_match_y", {31'd0, y}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap_y_after", {31'd0, y}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("stop_bit_y", {31'd0, y}, 32'd0);
    checkOutput("stop_bit_busy", {31'd0, busy}, 32'd0);
    checkOutput("stop_bit_count", {16'd0, match_count}, 32'd1);

    // saturation on the narrow counter, then start+stop together
    doReset();
    configure(8'h01, 4'd1, 1'b1);
    pulseStart(1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkOutput("sat_count2", {30'd0, match_count2}, 32'd3);
    checkOutput("sat_count16", {16'd0, match_count}, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    pulseStart(1'b1);
    checkOutput("startstop_busy", {31'd0, busy2}, 32'd0);
    checkOutput("startstop_err", {31'd0, err2}, 32'd0);
    checkOutput("startstop_count", {30'd0, match_count2}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
